turn_scheduler: RTL and testbench

- Sequences the tic-tac-toe game and owns the single write port of the board matrix memory.
- Alternates turns between the human (accept pulse plus cursor cell) and the CPU random-move engine, requesting CPU moves and validating every move against the current board.
- After each committed move, evaluates victory and draw and publishes turn and game-over status for the VGA layer.

---
 rtl/tictactoe_pkg.sv | 29 ++
 rtl/first_empty_cell.sv | 26 ++
 rtl/turn_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_turn_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe game sequencer: cell codes, board
// size, scheduler state encoding and a cell validity helper.
package tictactoe_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_HUMAN = 2'b01;
    localparam logic [1:0] CELL_CPU   = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {
        HUM_TURN = 3'd0,
        HUM_WR   = 3'd1,
        CPU_REQ  = 3'd2,
        CPU_WAIT = 3'd3,
        CPU_WR   = 3'd4,
        SETTLE   = 3'd5,
        OVER     = 3'd6
    } sched_state_t;

    // A cell may be played when it is on the board and its field is empty.
    function automatic logic cell_is_free(input logic [17:0] m, input logic [3:0] c);
        logic [17:0] sh;
        sh = m >> {c, 1'b0};
        return (c <= 4'd8) && (sh[1:0] == CELL_EMPTY);
    endfunction

endpackage

// File: rtl/first_empty_cell.sv
// Combinational scan of the board for the lowest-index empty cell. Used for
// the CPU fallback move and for the full-board (draw) check.
module first_empty_cell
    import tictactoe_pkg::*;
(
    input  logic [17:0] matrix,
    output logic [3:0]  first_idx,
    output logic        any_empty
);

    // Priority scan from cell 0 upward; the first empty field wins.
    always_comb begin
        first_idx = 4'd0;
        any_empty = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (!any_empty && (matrix[2*i +: 2] == CELL_EMPTY)) begin
                first_idx = 4'(i);
                any_empty = 1'b1;
            end else begin
                first_idx = first_idx;
                any_empty = any_empty;
            end
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Tic-tac-toe turn sequencer. Alternates human and CPU moves, validates each
// move against the board, owns the board write port and publishes turn and
// game-over status. All outputs are registered; each output register is
// loaded from a value derived from the next state, so a strobe is visible in
// the same cycle the FSM sits in the corresponding state.
// Optional build macro TURN_TIMER_EN adds a human turn time limit.
module turn_scheduler
    import tictactoe_pkg::*;
#(
    parameter int CPU_FIRST    = 0,
    parameter int CPU_TIMEOUT  = 64,
    parameter int TURN_TIMEOUT = 500000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        hum_accept,
    input  logic [3:0]  hum_cell,
    input  logic        rnd_found,
    input  logic [3:0]  rnd_cell,
    input  logic [17:0] matrix,
    input  logic        victory,
    output logic        gen_turn,
    output logic        wr_en,
    output logic [3:0]  wr_cell,
    output logic [1:0]  wr_player,
    output logic [1:0]  turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        move_reject,
    output logic        timeout
);

    localparam sched_state_t INIT_STATE = (CPU_FIRST != 0) ? CPU_REQ : HUM_TURN;
    localparam logic [1:0]   INIT_TURN  = (CPU_FIRST != 0) ? CELL_CPU : CELL_HUMAN;
    localparam int           CW         = ($clog2(CPU_TIMEOUT + 1) < 1) ? 1 : $clog2(CPU_TIMEOUT + 1);
    localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_TIMEOUT - 1);

    sched_state_t  state_q, state_d;
    logic          gen_turn_q, gen_turn_d;
    logic          wr_en_q, wr_en_d;
    logic [3:0]    wr_cell_q, wr_cell_d;
    logic [1:0]    wr_player_q, wr_player_d;
    logic [1:0]    turn_q, turn_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    winner_q, winner_d;
    logic          move_reject_q, move_reject_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;

    logic [3:0]    fe_idx;
    logic          fe_any;
    logic          hum_ok;
    logic          rnd_ok;
    logic          hum_expired;

    first_empty_cell u_first_empty (
        .matrix    (matrix),
        .first_idx (fe_idx),
        .any_empty (fe_any)
    );

    assign hum_ok = cell_is_free(matrix, hum_cell);
    assign rnd_ok = cell_is_free(matrix, rnd_cell);

`ifdef TURN_TIMER_EN
    localparam int            TW        = ($clog2(TURN_TIMEOUT + 1) < 1) ? 1 : $clog2(TURN_TIMEOUT + 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_TIMEOUT - 1);

    logic [TW-1:0] hum_cnt_q, hum_cnt_d;

    assign hum_expired = (state_q == HUM_TURN) && (hum_cnt_q == TURN_LAST);

    // Human turn timer: zero outside HUM_TURN (so it starts fresh on entry),
    // counts while the human deliberates; rejected moves do not restart it.
    always_comb begin
        hum_cnt_d = hum_cnt_q;
        if (new_game || (state_q != HUM_TURN)) begin
            hum_cnt_d = '0;
        end else if (hum_cnt_q != TURN_LAST) begin
            hum_cnt_d = hum_cnt_q + TW'(1);
        end else begin
            hum_cnt_d = hum_cnt_q;
        end
    end

    // Human turn timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hum_cnt_q <= '0;
        end else begin
            hum_cnt_q <= hum_cnt_d;
        end
    end
`else
    assign hum_expired = 1'b0;
`endif

    // Game sequencing: next state plus the latched move and result fields.
    always_comb begin
        state_d       = state_q;
        wr_cell_d     = wr_cell_q;
        wr_player_d   = wr_player_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        move_reject_d = 1'b0;
        timeout_d     = 1'b0;
        if (new_game) begin
            // Restart wins over every same-cycle event, so no write follows.
            state_d     = INIT_STATE;
            wr_cell_d   = 4'd0;
            wr_player_d = CELL_EMPTY;
            game_over_d = 1'b0;
            winner_d    = CELL_EMPTY;
        end else begin
            case (state_q)
                HUM_TURN: begin
                    if (hum_accept && hum_ok) begin
                        wr_cell_d   = hum_cell;
                        wr_player_d = CELL_HUMAN;
                        state_d     = HUM_WR;
                    end else if (hum_expired) begin
                        timeout_d = 1'b1;
                        state_d   = CPU_REQ;
                    end else if (hum_accept) begin
                        move_reject_d = 1'b1;
                    end else begin
                        state_d = HUM_TURN;
                    end
                end
                HUM_WR: begin
                    state_d = SETTLE;
                end
                CPU_REQ: begin
                    // Stay one extra cycle if the request pulse has not been
                    // issued yet (only possible straight out of reset).
                    if (gen_turn_q) begin
                        state_d = CPU_WAIT;
                    end else begin
                        state_d = CPU_REQ;
                    end
                end
                CPU_WAIT: begin
                    if (rnd_found && rnd_ok) begin
                        wr_cell_d   = rnd_cell;
                        wr_player_d = CELL_CPU;
                        state_d     = CPU_WR;
                    end else if (cpu_cnt_q == CPU_LAST) begin
                        wr_cell_d   = fe_idx;
                        wr_player_d = CELL_CPU;
                        state_d     = CPU_WR;
                    end else if (rnd_found) begin
                        state_d = CPU_REQ;
                    end else begin
                        state_d = CPU_WAIT;
                    end
                end
                CPU_WR: begin
                    state_d = SETTLE;
                end
                SETTLE: begin
                    // The board now reflects the last write; the mover is
                    // still held in wr_player_q.
                    if (victory) begin
                        winner_d    = wr_player_q;
                        game_over_d = 1'b1;
                        state_d     = OVER;
                    end else if (!fe_any) begin
                        winner_d    = WIN_DRAW;
                        game_over_d = 1'b1;
                        state_d     = OVER;
                    end else if (wr_player_q == CELL_HUMAN) begin
                        state_d = CPU_REQ;
                    end else begin
                        state_d = HUM_TURN;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = INIT_STATE;
                end
            endcase
        end
    end

    // CPU wait counter: restarts when a fresh request begins, keeps running
    // across re-requests so the fallback bound covers the whole CPU turn.
    always_comb begin
        cpu_cnt_d = cpu_cnt_q;
        if (new_game || ((state_d == CPU_REQ) && (state_q != CPU_WAIT))) begin
            cpu_cnt_d = '0;
        end else if (state_q == CPU_WAIT) begin
            cpu_cnt_d = cpu_cnt_q + CW'(1);
        end else begin
            cpu_cnt_d = cpu_cnt_q;
        end
    end

    // Strobe and turn outputs follow the state being entered.
    always_comb begin
        gen_turn_d = (state_d == CPU_REQ);
        wr_en_d    = (state_d == HUM_WR) || (state_d == CPU_WR);
        case (state_d)
            HUM_TURN, HUM_WR:          turn_d = CELL_HUMAN;
            CPU_REQ, CPU_WAIT, CPU_WR: turn_d = CELL_CPU;
            SETTLE:                    turn_d = turn_q;
            OVER:                      turn_d = CELL_EMPTY;
            default:                   turn_d = CELL_EMPTY;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= INIT_STATE;
            gen_turn_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_cell_q     <= 4'd0;
            wr_player_q   <= CELL_EMPTY;
            turn_q        <= INIT_TURN;
            game_over_q   <= 1'b0;
            winner_q      <= CELL_EMPTY;
            move_reject_q <= 1'b0;
            timeout_q     <= 1'b0;
            cpu_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gen_turn_q    <= gen_turn_d;
            wr_en_q       <= wr_en_d;
            wr_cell_q     <= wr_cell_d;
            wr_player_q   <= wr_player_d;
            turn_q        <= turn_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            move_reject_q <= move_reject_d;
            timeout_q     <= timeout_d;
            cpu_cnt_q     <= cpu_cnt_d;
        end
    end

    assign gen_turn    = gen_turn_q;
    assign wr_en       = wr_en_q;
    assign wr_cell     = wr_cell_q;
    assign wr_player   = wr_player_q;
    assign turn        = turn_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign move_reject = move_reject_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed testbench for turn_scheduler. A small board memory model reacts to
// the write port and supplies the matrix and victory inputs.
module tb_turn_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic        hum_accept = 1'b0;
    logic [3:0]  hum_cell = 4'd0;
    logic        rnd_found = 1'b0;
    logic [3:0]  rnd_cell = 4'd0;
    logic [17:0] board = 18'h0;
    logic        victory;
    logic        gen_turn, wr_en, game_over, move_reject, timeout;
    logic [3:0]  wr_cell;
    logic [1:0]  wr_player, turn, winner;

    logic        load_en = 1'b0;
    logic [17:0] load_val = 18'h0;

    int total = 0;
    int bad = 0;

    turn_scheduler #(
        .CPU_FIRST    (0),
        .CPU_TIMEOUT  (64),
        .TURN_TIMEOUT (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .hum_accept  (hum_accept),
        .hum_cell    (hum_cell),
        .rnd_found   (rnd_found),
        .rnd_cell    (rnd_cell),
        .matrix      (board),
        .victory     (victory),
        .gen_turn    (gen_turn),
        .wr_en       (wr_en),
        .wr_cell     (wr_cell),
        .wr_player   (wr_player),
        .turn        (turn),
        .game_over   (game_over),
        .winner      (winner),
        .move_reject (move_reject),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Board memory: registered write, preload for directed setups.
    always @(posedge clk) begin
        if (load_en) board <= load_val;
        else if (wr_en) board[2*wr_cell +: 2] <= wr_player;
    end

    function automatic logic line3(input logic [17:0] b, input int a, input int c, input int d);
        return (b[2*a +: 2] != 2'b00) && (b[2*a +: 2] == b[2*c +: 2]) && (b[2*a +: 2] == b[2*d +: 2]);
    endfunction

    function automatic logic win3(input logic [17:0] b);
        return line3(b,0,1,2) || line3(b,3,4,5) || line3(b,6,7,8) || line3(b,0,3,6) ||
               line3(b,1,4,7) || line3(b,2,5,8) || line3(b,0,4,8) || line3(b,2,4,6);
    endfunction

    assign victory = win3(board);

    // Board from a 9-character picture: H human, C CPU, anything else empty.
    function automatic logic [17:0] mkb(input string s);
        logic [17:0] b;
        byte ch;
        b = 18'h0;
        for (int i = 0; i < 9; i++) begin
            ch = s[i];
            if (ch == "H") b[2*i +: 2] = 2'b01;
            else if (ch == "C") b[2*i +: 2] = 2'b10;
        end
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [17:0] b);
        load_en = 1'b1; load_val = b; new_game = 1'b1;
        tick;
        load_en = 1'b0; new_game = 1'b0;
    endtask

    task automatic test_reset;
        logic [14:0] obs, expv;
        expv = {1'b0, 1'b0, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
        obs  = {gen_turn, wr_en, wr_cell, wr_player, turn, game_over, winner, move_reject, timeout};
        total++; if (obs !== expv) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs, expv); end
        rst = 1'b0;
        tick;
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL reset_turn: got %b want 01", turn); end
        total++; if (gen_turn !== 1'b0) begin bad++; $display("FAIL reset_gen_turn: got %b want 0", gen_turn); end
    endtask

    task automatic test_human_valid;
        start_game(18'h0);
        hum_accept = 1'b1; hum_cell = 4'd4;
        tick;
        hum_accept = 1'b0;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL hv_wr_en: got %b want 1", wr_en); end
        total++; if (wr_cell !== 4'd4) begin bad++; $display("FAIL hv_wr_cell: got %0d want 4", wr_cell); end
        total++; if (wr_player !== 2'b01) begin bad++; $display("FAIL hv_wr_player: got %b want 01", wr_player); end
        tick;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL hv_settle_wr_en: got %b want 0", wr_en); end
        total++; if (gen_turn !== 1'b0) begin bad++; $display("FAIL hv_settle_gen: got %b want 0", gen_turn); end
        tick;
        total++; if (gen_turn !== 1'b1) begin bad++; $display("FAIL hv_gen_turn: got %b want 1", gen_turn); end
        total++; if (turn !== 2'b10) begin bad++; $display("FAIL hv_turn_cpu: got %b want 10", turn); end
        tick;
        total++; if (gen_turn !== 1'b0) begin bad++; $display("FAIL hv_gen_once: got %b want 0", gen_turn); end
    endtask

    task automatic test_cpu_retry;
        // In CPU_WAIT: occupied cell plus a stray human accept.
        rnd_found = 1'b1; rnd_cell = 4'd4; hum_accept = 1'b1; hum_cell = 4'd0;
        tick;
        rnd_found = 1'b0; hum_accept = 1'b0;
        total++; if (gen_turn !== 1'b1) begin bad++; $display("FAIL retry_regen: got %b want 1", gen_turn); end
        total++; if (move_reject !== 1'b0) begin bad++; $display("FAIL retry_no_reject: got %b want 0", move_reject); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL retry_no_write: got %b want 0", wr_en); end
        // rnd_found during CPU_REQ is ignored.
        rnd_found = 1'b1; rnd_cell = 4'd0;
        tick;
        rnd_found = 1'b0;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL req_ignore_found: got %b want 0", wr_en); end
        // Out-of-range cell.
        rnd_found = 1'b1; rnd_cell = 4'd9;
        tick;
        rnd_found = 1'b0;
        total++; if (gen_turn !== 1'b1) begin bad++; $display("FAIL retry_range: got %b want 1", gen_turn); end
        tick;
        rnd_found = 1'b1; rnd_cell = 4'd0;
        tick;
        rnd_found = 1'b0;
        total++; if ({wr_en, wr_cell, wr_player} !== {1'b1, 4'd0, 2'b10}) begin bad++; $display("FAIL cpu_write: got %b/%0d/%b want 1/0/10", wr_en, wr_cell, wr_player); end
        tick;
        tick;
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL cpu_handback: got %b want 01", turn); end
    endtask

    task automatic test_human_invalid;
        hum_accept = 1'b1; hum_cell = 4'd4;
        tick;
        hum_accept = 1'b0;
        total++; if (move_reject !== 1'b1) begin bad++; $display("FAIL inv_occupied: got %b want 1", move_reject); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL inv_occ_write: got %b want 0", wr_en); end
        tick;
        total++; if (move_reject !== 1'b0) begin bad++; $display("FAIL inv_pulse_len: got %b want 0", move_reject); end
        hum_accept = 1'b1; hum_cell = 4'd12;
        tick;
        hum_accept = 1'b0;
        total++; if (move_reject !== 1'b1) begin bad++; $display("FAIL inv_range: got %b want 1", move_reject); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL inv_range_write: got %b want 0", wr_en); end
        tick;
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL inv_turn: got %b want 01", turn); end
    endtask

    task automatic test_cpu_fallback;
        int n;
        start_game(mkb("HCH......"));
        hum_accept = 1'b1; hum_cell = 4'd8;
        tick;
        hum_accept = 1'b0;
        tick;
        tick;
        total++; if (gen_turn !== 1'b1) begin bad++; $display("FAIL fb_gen_turn: got %b want 1", gen_turn); end
        n = 0;
        do begin
            tick;
            n++;
        end while (wr_en !== 1'b1 && n < 100);
        total++; if (n !== 65) begin bad++; $display("FAIL fb_latency: got %0d cycles want 65", n); end
        total++; if ({wr_cell, wr_player} !== {4'd3, 2'b10}) begin bad++; $display("FAIL fb_cell: got %0d/%b want 3/10", wr_cell, wr_player); end
        tick;
        tick;
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL fb_handback: got %b want 01", turn); end
    endtask

    task automatic test_victory;
        int seen;
        start_game(mkb("HH.CC...."));
        hum_accept = 1'b1; hum_cell = 4'd2;
        tick;
        hum_accept = 1'b0;
        tick;
        total++; if (game_over !== 1'b0) begin bad++; $display("FAIL win_early: got %b want 0", game_over); end
        tick;
        total++; if ({winner, game_over, turn} !== {2'b01, 1'b1, 2'b00}) begin bad++; $display("FAIL win_result: got %b/%b/%b want 01/1/00", winner, game_over, turn); end
        total++; if (gen_turn !== 1'b0) begin bad++; $display("FAIL win_no_req: got %b want 0", gen_turn); end
        hum_accept = 1'b1; hum_cell = 4'd5; rnd_found = 1'b1; rnd_cell = 4'd6;
        tick;
        hum_accept = 1'b0; rnd_found = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr_en || move_reject || gen_turn) seen++;
            tick;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL over_ignores: got %0d activity cycles want 0", seen); end
        total++; if ({winner, game_over} !== {2'b01, 1'b1}) begin bad++; $display("FAIL over_hold: got %b/%b want 01/1", winner, game_over); end
    endtask

    task automatic test_draw;
        start_game(mkb("HCHHCCCH."));
        hum_accept = 1'b1; hum_cell = 4'd8;
        tick;
        hum_accept = 1'b0;
        tick;
        tick;
        total++; if ({winner, game_over, turn} !== {2'b11, 1'b1, 2'b00}) begin bad++; $display("FAIL draw_result: got %b/%b/%b want 11/1/00", winner, game_over, turn); end
        // new_game together with a valid accept: restart wins, no write.
        load_en = 1'b1; load_val = 18'h0; new_game = 1'b1; hum_accept = 1'b1; hum_cell = 4'd4;
        tick;
        load_en = 1'b0; new_game = 1'b0; hum_accept = 1'b0;
        total++; if ({winner, game_over, turn} !== {2'b00, 1'b0, 2'b01}) begin bad++; $display("FAIL ng_clear: got %b/%b/%b want 00/0/01", winner, game_over, turn); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL ng_no_write: got %b want 0", wr_en); end
        tick;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL ng_no_write_late: got %b want 0", wr_en); end
    endtask

    task automatic test_rst_mid_cpu;
        logic [14:0] obs, expv;
        start_game(18'h0);
        hum_accept = 1'b1; hum_cell = 4'd4;
        tick;
        hum_accept = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        #1;
        expv = {1'b0, 1'b0, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
        obs  = {gen_turn, wr_en, wr_cell, wr_player, turn, game_over, winner, move_reject, timeout};
        total++; if (obs !== expv) begin bad++; $display("FAIL rst_async: got %h want %h", obs, expv); end
        tick;
        rst = 1'b0;
        rnd_found = 1'b1; rnd_cell = 4'd0;
        tick;
        rnd_found = 1'b0;
        total++; if ({wr_en, gen_turn, turn} !== {1'b0, 1'b0, 2'b01}) begin bad++; $display("FAIL rst_late_found: got %b/%b/%b want 0/0/01", wr_en, gen_turn, turn); end
        tick;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_late_write: got %b want 0", wr_en); end
    endtask

`ifdef TURN_TIMER_EN
    task automatic test_turn_timer;
        int n;
        start_game(18'h0);
        n = 0;
        do begin
            tick;
            n++;
        end while (timeout !== 1'b1 && n < 50);
        total++; if (n !== 10) begin bad++; $display("FAIL tmr_latency: got %0d want 10", n); end
        total++; if ({gen_turn, wr_en} !== {1'b1, 1'b0}) begin bad++; $display("FAIL tmr_forfeit: got %b/%b want 1/0", gen_turn, wr_en); end
        tick;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmr_pulse_len: got %b want 0", timeout); end
    endtask
`else
    task automatic test_turn_timer;
        int seen;
        start_game(18'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (timeout || gen_turn) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL no_timer: got %0d events want 0", seen); end
        total++; if (turn !== 2'b01) begin bad++; $display("FAIL no_timer_turn: got %b want 01", turn); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        test_reset;
        test_human_valid;
        test_cpu_retry;
        test_human_invalid;
        test_cpu_fallback;
        test_victory;
        test_draw;
        test_rst_mid_cpu;
        test_turn_timer;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
